usb_audio_packer: RTL

- Multi-channel PCM-to-USB packetizer. Sits between the audio DSP chain (mic/AEC/FIR outputs) and the usb_fifo endpoint TX data port.
- Buffers interleaved sample frames and emits one fixed-length isochronous payload per SOF.
- Pads with zeros when the buffer underruns and drops input when it overruns.
- Streams only while the interface alternate setting is non-zero.

---
 rtl/usb_audio_packer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/usb_audio_packer.sv
// rtl/usb_audio_packer.sv - multi-channel PCM to USB isochronous payload packetizer
module usb_audio_packer #(
    parameter int NUM_CH        = 4,
    parameter int SAMPLE_W      = 16,
    parameter int FIFO_DEPTH    = 64,
    parameter int FRAME_SAMPLES = 6
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [7:0]                      alt_setting_i,
    input  logic                            sof_i,
    input  logic                            pcm_valid_i,
    input  logic [NUM_CH*SAMPLE_W-1:0]      pcm_data_i,
    input  logic                            ep_tx_rdy_i,
    output logic                            ep_tx_dval_o,
    output logic [7:0]                      ep_tx_data_o,
    output logic [11:0]                     pkt_len_o,
    output logic [$clog2(FIFO_DEPTH):0]     fill_o,
    output logic [15:0]                     overrun_cnt_o,
    output logic [15:0]                     underrun_cnt_o,
    output logic                            busy_o
);

    localparam int FW          = NUM_CH * SAMPLE_W;
    localparam int FRAME_BYTES = FW / 8;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;
    localparam int BW          = $clog2(FRAME_BYTES) + 1;
    localparam int FCW         = $clog2(FRAME_SAMPLES) + 1;

    localparam logic [BW-1:0]  LAST_BYTE  = BW'(FRAME_BYTES - 1);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(FRAME_SAMPLES - 1);
    localparam logic [CW-1:0]  FULL_CNT   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_LOAD,
        S_SEND
    } state_t;

    state_t          state_q, state_d;
    logic            en_q;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic            pad_q, pad_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     ovr_q, und_q;
    logic [FW-1:0]   mem [FIFO_DEPTH];

    logic            pop;
    logic            und_inc;
    logic            push_ok;
    logic            drop;

    // A pop in the same cycle frees a slot, so a push at full is only a drop without one.
    assign push_ok = en_q & pcm_valid_i & ((count_q != FULL_CNT) | pop);
    assign drop    = en_q & pcm_valid_i & (count_q == FULL_CNT) & ~pop;

    assign ep_tx_dval_o   = en_q & (state_q == S_SEND);
    assign ep_tx_data_o   = shreg_q[7:0];
    assign busy_o         = (state_q == S_LOAD) | (state_q == S_SEND);
    assign pkt_len_o      = 12'(FRAME_BYTES * FRAME_SAMPLES);
    assign fill_o         = count_q;
    assign overrun_cnt_o  = ovr_q;
    assign underrun_cnt_o = und_q;

    // Register the streaming enable once from the alternate setting.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= (alt_setting_i != 8'd0);
        end
    end

    // Packet sequencer next-state: frame loading, byte shifting, underrun padding.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        fcnt_d  = fcnt_q;
        shreg_d = shreg_q;
        pad_d   = pad_q;
        pop     = 1'b0;
        und_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (sof_i) begin
                    state_d = S_LOAD;
                    fcnt_d  = '0;
                    pad_d   = 1'b0;
                end
            end
            S_LOAD: begin
                // Once a packet has padded, stay padded so real frames never follow zeros.
                if ((count_q != '0) && !pad_q) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                end else begin
                    shreg_d = '0;
                    und_inc = 1'b1;
                    pad_d   = 1'b1;
                end
                bcnt_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (ep_tx_rdy_i) begin
                    shreg_d = shreg_q >> 8;
                    bcnt_d  = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_BYTE) begin
                        fcnt_d  = fcnt_q + 1'b1;
                        state_d = (fcnt_q == LAST_FRAME) ? S_WAIT_SOF : S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!en_q) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            und_inc = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            fcnt_q  <= '0;
            shreg_q <= '0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            fcnt_q  <= fcnt_d;
            shreg_q <= shreg_d;
            pad_q   <= pad_d;
        end
    end

    // Frame buffer storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= pcm_data_i;
        end
    end

    // Frame buffer pointers and fill count; flushed while streaming is off.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!en_q) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Saturating overrun and underrun event counters, kept across disable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovr_q <= '0;
            und_q <= '0;
        end else begin
            if (drop && (ovr_q != 16'hFFFF)) begin
                ovr_q <= ovr_q + 16'd1;
            end
            if (und_inc && (und_q != 16'hFFFF)) begin
                und_q <= und_q + 16'd1;
            end
        end
    end

endmodule
